// File: rtl/imem_loader_if.sv
// Byte-stream input and imem byte-write bus used by the instruction-memory loader.
interface imem_loader_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    // Stream source / memory sink side
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    // Loader side
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: copies a checksummed byte stream into imem and
// releases the core's PC reset only after the trailing checksum byte matches.
module imem_loader #(
    parameter int MEM_BYTES = 100,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       len,
    imem_loader_if.slave      bus,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {IDLE, LOAD, CHK, DONE, ERR} state_t;

    localparam logic [15:0] MAX_LEN = 16'(MEM_BYTES);

    state_t            state, state_n;

    logic [15:0]       cnt, cnt_d;
    logic [7:0]        sum, sum_d;
    logic [15:0]       len_q, len_d;
    logic              in_ready_q, in_ready_d;
    logic              we_p1, we_d;
    logic [ADDR_W-1:0] addr_p1, addr_d;
    logic [7:0]        wdata_p1, wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              rstn_q, rstn_d;

    logic              xfer;
    logic              len_ok;
    logic              last_byte;
    logic              sum_ok;

    // Modulo-256 accumulate used for the running checksum.
    function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

    assign xfer      = bus.in_valid & in_ready_q;
    assign len_ok    = (len != 16'd0) && (len <= MAX_LEN);
    assign last_byte = (cnt == len_q - 16'd1);
    assign sum_ok    = (sum8(sum, bus.in_data) == 8'd0);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode; start is only honoured while not loading.
    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_n = len_ok ? LOAD : ERR;
                end
            end
            LOAD: begin
                if (xfer && last_byte) begin
                    state_n = CHK;
                end
            end
            CHK: begin
                if (xfer) begin
                    state_n = sum_ok ? DONE : ERR;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Output / datapath decode; every output is registered from these values.
    always_comb begin
        cnt_d      = cnt;
        sum_d      = sum;
        len_d      = len_q;
        we_d       = 1'b0;
        addr_d     = addr_p1;
        wdata_d    = wdata_p1;
        done_d     = done_q;
        err_d      = err_q;
        rstn_d     = rstn_q;
        in_ready_d = (state_n == LOAD) || (state_n == CHK);
        busy_d     = (state_n == LOAD) || (state_n == CHK);
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    done_d = 1'b0;
                    rstn_d = 1'b0;
                    if (len_ok) begin
                        len_d = len;
                        cnt_d = 16'd0;
                        sum_d = 8'd0;
                        err_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (xfer) begin
                    we_d    = 1'b1;
                    addr_d  = ADDR_W'(cnt);
                    wdata_d = bus.in_data;
                    sum_d   = sum8(sum, bus.in_data);
                    cnt_d   = cnt + 16'd1;
                end
            end
            CHK: begin
                // The checksum byte is consumed but never written to imem.
                if (xfer) begin
                    done_d = sum_ok;
                    err_d  = !sum_ok;
                    rstn_d = sum_ok;
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= 16'd0;
            sum        <= 8'd0;
            len_q      <= 16'd0;
            in_ready_q <= 1'b0;
            we_p1      <= 1'b0;
            addr_p1    <= '0;
            wdata_p1   <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rstn_q     <= 1'b0;
        end else begin
            cnt        <= cnt_d;
            sum        <= sum_d;
            len_q      <= len_d;
            in_ready_q <= in_ready_d;
            we_p1      <= we_d;
            addr_p1    <= addr_d;
            wdata_p1   <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rstn_q     <= rstn_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = we_p1;
    assign bus.mem_addr  = addr_p1;
    assign bus.mem_wdata = wdata_p1;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign cpu_rst_n     = rstn_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good loads, bad checksums, bad lengths,
// stream bubbles, mid-load reset, start held during a load, and a full-size load.
module tb_imem_loader;

    localparam int MEM_BYTES = 100;
    localparam int ADDR_W    = 32;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] len   = 16'd0;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic        err;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .bus       (bus),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int         checks    = 0;
    int         failures  = 0;
    int         wr_cnt    = 0;
    int         ready_cnt = 0;
    int         w0;
    int         r0;
    logic [7:0] tb_mem [0:127];

    // Memory model and activity counters observed at each active edge.
    always @(posedge clk) begin
        if (bus.mem_we) begin
            tb_mem[bus.mem_addr[6:0]] <= bus.mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (bus.in_ready) begin
            ready_cnt <= ready_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chkb(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, got, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Issue a start with a valid length and confirm the loader entered LOAD.
    task automatic do_start(input logic [15:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
        chkb("start_ready", bus.in_ready, 1'b1);
        chkb("start_busy", busy, 1'b1);
        chkb("start_done_clr", done, 1'b0);
        chkb("start_err_clr", err, 1'b0);
        chkb("start_cpu_held", cpu_rst_n, 1'b0);
    endtask

    // One accepted payload byte; the write appears in the following cycle.
    task automatic push(input logic [7:0] d, input int exp_addr);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
        chkb("push_we", bus.mem_we, 1'b1);
        chk32("push_addr", bus.mem_addr, exp_addr);
        chk8("push_data", bus.mem_wdata, d);
    endtask

    // A cycle with no stream byte offered; junk data must not be written.
    task automatic bubble();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'hFF;
        tick();
        chkb("bubble_no_we", bus.mem_we, 1'b0);
    endtask

    // Checksum byte: consumed, never written.
    task automatic send_sum(input logic [7:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
        chkb("sum_no_we", bus.mem_we, 1'b0);
        chkb("sum_ready_low", bus.in_ready, 1'b0);
        chkb("sum_busy_low", busy, 1'b0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // ---- reset state ----
        reset = 1'b1;
        tick();
        tick();
        chkb("rst_ready", bus.in_ready, 1'b0);
        chkb("rst_we", bus.mem_we, 1'b0);
        chk32("rst_addr", bus.mem_addr, 0);
        chk8("rst_wdata", bus.mem_wdata, 8'h00);
        chkb("rst_cpu", cpu_rst_n, 1'b0);
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_done", done, 1'b0);
        chkb("rst_err", err, 1'b0);
        reset = 1'b0;
        tick();

        // ---- len = MEM_BYTES+1 from IDLE is rejected ----
        start = 1'b1;
        len   = 16'd101;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        tick();
        start = 1'b0;
        chkb("len101_err", err, 1'b1);
        chkb("len101_done", done, 1'b0);
        chkb("len101_ready", bus.in_ready, 1'b0);
        chkb("len101_busy", busy, 1'b0);
        tick();
        tick();
        chkb("len101_no_we", bus.mem_we, 1'b0);
        chk32("len101_wr_cnt", wr_cnt, 0);
        chk32("len101_ready_cnt", ready_cnt, 0);
        bus.in_valid = 1'b0;

        // ---- good load of 34 08 00 0B; sum 0x47, checksum 0xB9 ----
        do_start(16'd4);
        push(8'h34, 0);
        push(8'h08, 1);
        push(8'h00, 2);
        push(8'h0B, 3);
        chkb("t1_chk_ready", bus.in_ready, 1'b1);
        chkb("t1_cpu_held_in_chk", cpu_rst_n, 1'b0);
        send_sum(8'hB9);
        chkb("t1_done", done, 1'b1);
        chkb("t1_err", err, 1'b0);
        chkb("t1_cpu_run", cpu_rst_n, 1'b1);
        tick();
        chk32("t1_wr_cnt", wr_cnt, 4);
        chk8("t1_mem0", tb_mem[0], 8'h34);
        chk8("t1_mem1", tb_mem[1], 8'h08);
        chk8("t1_mem2", tb_mem[2], 8'h00);
        chk8("t1_mem3", tb_mem[3], 8'h0B);

        // ---- len = 0 from DONE is rejected and clears done ----
        r0 = ready_cnt;
        start = 1'b1;
        len   = 16'd0;
        tick();
        start = 1'b0;
        chkb("len0_err", err, 1'b1);
        chkb("len0_done", done, 1'b0);
        chkb("len0_cpu", cpu_rst_n, 1'b0);
        chkb("len0_ready", bus.in_ready, 1'b0);
        tick();
        chk32("len0_ready_cnt", ready_cnt, r0);
        chk32("len0_wr_cnt", wr_cnt, 4);

        // ---- bad checksum B4 ----
        do_start(16'd4);
        push(8'h34, 0);
        push(8'h08, 1);
        push(8'h00, 2);
        push(8'h0B, 3);
        send_sum(8'hB4);
        chkb("t2_err", err, 1'b1);
        chkb("t2_done", done, 1'b0);
        chkb("t2_cpu", cpu_rst_n, 1'b0);
        tick();
        tick();
        chkb("t2_cpu_still", cpu_rst_n, 1'b0);
        chk32("t2_wr_cnt", wr_cnt, 8);

        // ---- bubbles: valid pattern 1,0,0,1,0,1 then checksum 0x9A ----
        do_start(16'd3);
        push(8'h11, 0);
        bubble();
        bubble();
        push(8'h22, 1);
        bubble();
        push(8'h33, 2);
        send_sum(8'h9A);
        chkb("t4_done", done, 1'b1);
        chkb("t4_cpu", cpu_rst_n, 1'b1);
        tick();
        chk32("t4_wr_cnt", wr_cnt, 11);
        chk8("t4_mem2", tb_mem[2], 8'h33);

        // ---- reset after 2 of 4 bytes, then a full load ----
        w0 = wr_cnt;
        do_start(16'd4);
        push(8'hA1, 0);
        push(8'hA2, 1);
        reset = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        tick();
        reset = 1'b0;
        chkb("t5_ready", bus.in_ready, 1'b0);
        chkb("t5_we", bus.mem_we, 1'b0);
        chk32("t5_addr", bus.mem_addr, 0);
        chk8("t5_wdata", bus.mem_wdata, 8'h00);
        chkb("t5_cpu", cpu_rst_n, 1'b0);
        chkb("t5_busy", busy, 1'b0);
        chkb("t5_done", done, 1'b0);
        chkb("t5_err", err, 1'b0);
        tick();
        tick();
        chkb("t5_idle_no_we", bus.mem_we, 1'b0);
        chk32("t5_wr_cnt", wr_cnt, w0 + 2);
        chk8("t5_mem1_kept", tb_mem[1], 8'hA2);
        bus.in_valid = 1'b0;
        do_start(16'd4);
        push(8'h34, 0);
        push(8'h08, 1);
        push(8'h00, 2);
        push(8'h0B, 3);
        send_sum(8'hB9);
        chkb("t5_reload_done", done, 1'b1);
        chkb("t5_reload_cpu", cpu_rst_n, 1'b1);

        // ---- start held high through LOAD/CHK with a bogus len ----
        start = 1'b1;
        len   = 16'd4;
        tick();
        len   = 16'd0;
        chkb("t6_busy", busy, 1'b1);
        chkb("t6_done_clr", done, 1'b0);
        chkb("t6_cpu_drop", cpu_rst_n, 1'b0);
        push(8'h34, 0);
        push(8'h08, 1);
        push(8'h00, 2);
        push(8'h0B, 3);
        send_sum(8'hB9);
        start = 1'b0;
        chkb("t6_done", done, 1'b1);
        chkb("t6_err", err, 1'b0);
        chkb("t6_cpu_run", cpu_rst_n, 1'b1);

        // ---- second start from DONE drops cpu_rst_n ----
        do_start(16'd1);
        push(8'h5A, 0);
        send_sum(8'hA6);
        chkb("t6b_done", done, 1'b1);
        chkb("t6b_cpu", cpu_rst_n, 1'b1);

        // ---- full-size load: bytes 0..99, sum 0x56, checksum 0xAA ----
        do_start(16'd100);
        for (int i = 0; i < 100; i++) begin
            push(8'(i), i);
        end
        send_sum(8'hAA);
        chkb("t7_done", done, 1'b1);
        chkb("t7_cpu", cpu_rst_n, 1'b1);
        tick();
        chk8("t7_mem99", tb_mem[99], 8'd99);
        chk8("t7_mem50", tb_mem[50], 8'd50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
